// File: rtl/m00_axi_lite_register_file_responder.sv
// AXI4-Lite register-file responder: control/start register, live status word,
// general-purpose 64-bit registers exported flat to kernel logic.

package m00_axi_lite_register_file_responder_pkg;
    localparam int unsigned M00_ADDR_W = 17;
    localparam int unsigned M00_DATA_W = 64;
    localparam int unsigned M00_STRB_W = M00_DATA_W / 8;

    typedef struct packed {
        logic [M00_ADDR_W-1:0] addr;
        logic [2:0]            prot;
    } M00_AXI4_LITE_MID_AX_T;

    typedef struct packed {
        logic [M00_DATA_W-1:0] data;
        logic [M00_STRB_W-1:0] strb;
    } M00_AXI4_LITE_MID_W_T;

    typedef struct packed {
        logic [1:0] resp;
    } M00_AXI4_LITE_MID_B_T;

    typedef struct packed {
        logic [M00_DATA_W-1:0] data;
        logic [1:0]            resp;
    } M00_AXI4_LITE_MID_R_T;

    typedef struct packed {
        M00_AXI4_LITE_MID_AX_T aw;
        logic                  aw_valid;
        M00_AXI4_LITE_MID_W_T  w;
        logic                  w_valid;
        logic                  b_ready;
        M00_AXI4_LITE_MID_AX_T ar;
        logic                  ar_valid;
        logic                  r_ready;
    } M00_AXI4_LITE_MID_REQ_T;

    typedef struct packed {
        logic                  aw_ready;
        logic                  w_ready;
        M00_AXI4_LITE_MID_B_T  b;
        logic                  b_valid;
        logic                  ar_ready;
        M00_AXI4_LITE_MID_R_T  r;
        logic                  r_valid;
    } M00_AXI4_LITE_MID_RESP_T;
endpackage

module m00_axi_lite_register_file_responder
    import m00_axi_lite_register_file_responder_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = M00_ADDR_W,
    parameter int unsigned DATA_W   = M00_DATA_W
) (
    input  logic                             ap_clk,
    input  logic                             areset,
    input  M00_AXI4_LITE_MID_REQ_T           s_axi_lite_in,
    output M00_AXI4_LITE_MID_RESP_T          s_axi_lite_out,
    input  logic [DATA_W-1:0]                status_in,
    output logic                             ctrl_start,
    output logic [(NUM_REGS-2)*DATA_W-1:0]   regs_out
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = ADDR_W - 3;
    localparam int unsigned NUM_GP = NUM_REGS - 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_COMMIT, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_CAPTURE, RD_RESP} rd_state_t;

    wr_state_t          r_wr_state;
    rd_state_t          r_rd_state;
    logic               r_aw_ready, r_w_ready, r_b_valid, r_ar_ready, r_r_valid;
    logic [1:0]         r_b_resp, r_r_resp;
    logic [DATA_W-1:0]  r_r_data;
    logic [IDX_W-1:0]   r_wr_idx, r_rd_idx;
    logic [DATA_W-1:0]  r_wr_data;
    logic [STRB_W-1:0]  r_wr_strb;
    logic               r_ctrl_start;
    logic [DATA_W-1:0]  r_ctrl;
    logic [DATA_W-1:0]  r_gp [NUM_GP];

    logic               w_aw_hs, w_w_hs, w_ar_hs;
    logic               w_wr_in_range, w_rd_in_range;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_unused_ok;

    assign w_aw_hs       = s_axi_lite_in.aw_valid & r_aw_ready;
    assign w_w_hs        = s_axi_lite_in.w_valid  & r_w_ready;
    assign w_ar_hs       = s_axi_lite_in.ar_valid & r_ar_ready;
    assign w_wr_in_range = (r_wr_idx < IDX_W'(NUM_REGS));
    assign w_rd_in_range = (r_rd_idx < IDX_W'(NUM_REGS));
    assign w_unused_ok   = ^{s_axi_lite_in.aw.addr[2:0], s_axi_lite_in.aw.prot,
                             s_axi_lite_in.ar.addr[2:0], s_axi_lite_in.ar.prot};

    // Byte-lane merge of new write data into an existing register value
    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_v,
                                                  input logic [DATA_W-1:0] new_v,
                                                  input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] v;
        v = old_v;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
        end
        return v;
    endfunction

    // Read data mux; sampled into r_r_data at capture
    always_comb begin
        w_rd_data = '0;
        if (w_rd_in_range) begin
            if (r_rd_idx == IDX_W'(0)) w_rd_data = r_ctrl;
            if (r_rd_idx == IDX_W'(1)) w_rd_data = status_in;
            for (int unsigned k = 0; k < NUM_GP; k++) begin
                if (r_rd_idx == IDX_W'(k + 2)) w_rd_data = r_gp[k];
            end
        end
    end

    // Write FSM, register bank update and start pulse
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_wr_state   <= WR_IDLE;
            r_aw_ready   <= 1'b0;
            r_w_ready    <= 1'b0;
            r_b_valid    <= 1'b0;
            r_b_resp     <= '0;
            r_wr_idx     <= '0;
            r_wr_data    <= '0;
            r_wr_strb    <= '0;
            r_ctrl_start <= 1'b0;
            r_ctrl       <= '0;
            for (int unsigned k = 0; k < NUM_GP; k++) r_gp[k] <= '0;
        end else begin
            r_ctrl_start <= 1'b0;
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_aw_hs) r_wr_idx <= s_axi_lite_in.aw.addr[ADDR_W-1:3];
                    if (w_w_hs) begin
                        r_wr_data <= s_axi_lite_in.w.data;
                        r_wr_strb <= s_axi_lite_in.w.strb;
                    end
                    if (w_aw_hs && w_w_hs) begin
                        r_wr_state <= WR_COMMIT;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b0;
                    end else if (w_aw_hs) begin
                        r_wr_state <= WR_WAIT_W;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wr_state <= WR_WAIT_AW;
                        r_aw_ready <= 1'b1;
                        r_w_ready  <= 1'b0;
                    end else begin
                        r_aw_ready <= 1'b1;
                        r_w_ready  <= 1'b1;
                    end
                end
                WR_WAIT_W: begin
                    if (w_w_hs) begin
                        r_wr_data  <= s_axi_lite_in.w.data;
                        r_wr_strb  <= s_axi_lite_in.w.strb;
                        r_wr_state <= WR_COMMIT;
                        r_w_ready  <= 1'b0;
                    end
                end
                WR_WAIT_AW: begin
                    if (w_aw_hs) begin
                        r_wr_idx   <= s_axi_lite_in.aw.addr[ADDR_W-1:3];
                        r_wr_state <= WR_COMMIT;
                        r_aw_ready <= 1'b0;
                    end
                end
                WR_COMMIT: begin
                    r_b_valid  <= 1'b1;
                    r_wr_state <= WR_RESP;
                    if (w_wr_in_range) begin
                        r_b_resp <= RESP_OKAY;
                        if (r_wr_idx == IDX_W'(0)) begin
                            // Start bit is never stored; it only fires the pulse
                            r_ctrl       <= f_merge(r_ctrl, r_wr_data, r_wr_strb) & ~DATA_W'(1);
                            r_ctrl_start <= r_wr_strb[0] & r_wr_data[0];
                        end
                        for (int unsigned k = 0; k < NUM_GP; k++) begin
                            if (r_wr_idx == IDX_W'(k + 2)) r_gp[k] <= f_merge(r_gp[k], r_wr_data, r_wr_strb);
                        end
                    end else begin
                        r_b_resp <= RESP_SLVERR;
                    end
                end
                WR_RESP: begin
                    if (s_axi_lite_in.b_ready) begin
                        r_b_valid  <= 1'b0;
                        r_b_resp   <= '0;
                        r_wr_state <= WR_IDLE;
                        r_aw_ready <= 1'b1;
                        r_w_ready  <= 1'b1;
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read FSM: capture one cycle after the AR handshake, hold until accepted
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_rd_state <= RD_IDLE;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_data   <= '0;
            r_r_resp   <= '0;
            r_rd_idx   <= '0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_rd_idx   <= s_axi_lite_in.ar.addr[ADDR_W-1:3];
                        r_rd_state <= RD_CAPTURE;
                        r_ar_ready <= 1'b0;
                    end else begin
                        r_ar_ready <= 1'b1;
                    end
                end
                RD_CAPTURE: begin
                    r_r_data   <= w_rd_data;
                    r_r_resp   <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    r_r_valid  <= 1'b1;
                    r_rd_state <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_axi_lite_in.r_ready) begin
                        r_r_valid  <= 1'b0;
                        r_r_data   <= '0;
                        r_r_resp   <= '0;
                        r_rd_state <= RD_IDLE;
                        r_ar_ready <= 1'b1;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    // Response struct assembled from registered state
    always_comb begin
        s_axi_lite_out          = '0;
        s_axi_lite_out.aw_ready = r_aw_ready;
        s_axi_lite_out.w_ready  = r_w_ready;
        s_axi_lite_out.b.resp   = r_b_resp;
        s_axi_lite_out.b_valid  = r_b_valid;
        s_axi_lite_out.ar_ready = r_ar_ready;
        s_axi_lite_out.r.data   = r_r_data;
        s_axi_lite_out.r.resp   = r_r_resp;
        s_axi_lite_out.r_valid  = r_r_valid;
    end

    assign ctrl_start = r_ctrl_start;

    // Flat export of the general-purpose registers
    for (genvar g = 0; g < NUM_GP; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = r_gp[g];
    end

endmodule
